mpmodsub: RTL and testbench

Multi-cycle 1027-bit modular subtractor computing (in_a − in_b) mod in_m for operands already reduced below the modulus. It shares the start/done handshake and the 514-bit half-split datapath of the multiprecision adder. It serves as that adder's inverse path in the modular arithmetic core. Subtraction runs low half first, then high half, with a registered borrow between them; an optional two-cycle correction pass adds the modulus back when the raw difference is negative.

---
 rtl/mpmodsub_if.sv | 13 +
 rtl/mpmodsub.sv | 89 ++++++++
 tb/tb_mpmodsub.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mpmodsub_if.sv
// mpmodsub_if: start/done handshake and operand/result bus of the modular subtractor.
interface mpmodsub_if;
  logic          start;
  logic [1026:0] in_a;
  logic [1026:0] in_b;
  logic [1026:0] in_m;
  logic [1026:0] result;
  logic          wrapped;
  logic          busy;
  logic          done;
  modport master (output start, in_a, in_b, in_m, input result, wrapped, busy, done);
  modport slave  (input start, in_a, in_b, in_m, output result, wrapped, busy, done);
endinterface

// File: rtl/mpmodsub.sv
// mpmodsub: multi-cycle 1027-bit (a - b) mod m over two half-width subtract steps,
// followed by an optional two-step add-back of m when the difference goes negative.
module mpmodsub (
  input logic        clk,
  input logic        resetn,
  mpmodsub_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SUB_LO, SUB_HI, COR_LO, COR_HI} state_t;
  state_t        state_q, state_d;
  logic [1026:0] a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic          wrapped_q, wrapped_d, done_q, done_d, borrow_q, borrow_d, carry_q, carry_d;
  logic [514:0]  diff_lo, sum_lo;
  logic [513:0]  diff_hi;
  logic [512:0]  sum_hi;
  assign diff_lo = {1'b0, a_q[513:0]} - {1'b0, b_q[513:0]};
  assign diff_hi = {1'b0, a_q[1026:514]} - {1'b0, b_q[1026:514]} - {513'b0, borrow_q};
  assign sum_lo  = {1'b0, result_q[513:0]} + {1'b0, m_q[513:0]};
  assign sum_hi  = result_q[1026:514] + m_q[1026:514] + {512'b0, carry_q};
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    result_d  = result_q;
    wrapped_d = wrapped_q;
    borrow_d  = borrow_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d       = bus.in_a;
        b_d       = bus.in_b;
        m_d       = bus.in_m;
        wrapped_d = 1'b0;
        state_d   = SUB_LO;
      end
      SUB_LO: begin
        result_d[513:0] = diff_lo[513:0];
        borrow_d        = diff_lo[514];
        state_d         = SUB_HI;
      end
      SUB_HI: begin
        // a borrow out of the top half means a < b: add m back
        result_d[1026:514] = diff_hi[512:0];
        wrapped_d          = diff_hi[513];
        done_d             = ~diff_hi[513];
        state_d            = diff_hi[513] ? COR_LO : IDLE;
      end
      COR_LO: begin
        result_d[513:0] = sum_lo[513:0];
        carry_d         = sum_lo[514];
        state_d         = COR_HI;
      end
      COR_HI: begin
        result_d[1026:514] = sum_hi;
        done_d             = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      result_q  <= '0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
      borrow_q  <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      result_q  <= result_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
      borrow_q  <= borrow_d;
      carry_q   <= carry_d;
    end
  end
  assign bus.result  = result_q;
  assign bus.wrapped = wrapped_q;
  assign bus.done    = done_q;
  assign bus.busy    = state_q != IDLE;
endmodule

// File: tb/tb_mpmodsub.sv
// tb_mpmodsub: scoreboard bench for mpmodsub; expectations come from a plain
// arithmetic model of (a - b) mod m, checked when done pulses.
module tb_mpmodsub;
  typedef struct {
    logic [1026:0] r;
    logic          w;
    int            cyc;
  } exp_t;
  logic clk;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;
  mpmodsub_if bus();
  mpmodsub dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1026:0] rnd();
    logic [1026:0] r = '0;
    for (int i = 0; i < 33; i++) r = {r[994:0], $urandom()};
    return r;
  endfunction

  function automatic exp_t model(input logic [1026:0] a, b, m, input int c0);
    exp_t x;
    logic [1027:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, m};
    x.r   = d[1026:0];
    x.w   = a < b;
    x.cyc = c0 + 1 + ((a < b) ? 4 : 2);
    return x;
  endfunction

  task automatic chk_w(input string n, input logic [1026:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (act[513:0] !== exp[513:0]) $display("FAIL %s lo half got %h want %h", n, act[513:0], exp[513:0]);
      else $display("FAIL %s hi half got %h want %h", n, act[1026:514], exp[1026:514]);
    end
  endtask

  task automatic chk_i(input string n, input int act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  always @(negedge clk) if (resetn && bus.done) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done got done=1 want no done at cycle %0d", cyc);
    end else begin
      e = sb.pop_front();
      chk_w("result", bus.result, e.r);
      chk_i("wrapped", int'(bus.wrapped), int'(e.w));
      chk_i("done_cycle", cyc, e.cyc);
      chk_i("busy_at_done", int'(bus.busy), 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin @(negedge clk); n++; end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy=1 want busy=0");
    end
  endtask

  task automatic op(input logic [1026:0] a, b, m);
    wait_idle();
    bus.start = 1'b1;
    bus.in_a  = a;
    bus.in_b  = b;
    bus.in_m  = m;
    sb.push_back(model(a, b, m, cyc));
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_a  = rnd();
    bus.in_b  = rnd();
    bus.in_m  = rnd();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0 || bus.busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    logic [1026:0] one, all1, pat, m, a, b;
    logic [1031:0] p;
    one  = 1;
    all1 = '1;
    p    = {129{8'h5A}};
    pat  = p[1026:0];
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.in_m  = '0;
    repeat (2) @(negedge clk);
    chk_w("reset_result", bus.result, '0);
    chk_i("reset_wrapped", int'(bus.wrapped), 0);
    chk_i("reset_done", int'(bus.done), 0);
    chk_i("reset_busy", int'(bus.busy), 0);
    resetn = 1'b1;
    @(negedge clk);
    op(10, 3, 17);
    op(3, 10, 17);
    op(one << 514, 1, one << 1026);
    op(0, 1, all1);
    op(pat, pat, all1);
    drain();
    // start held high: accepted only when idle, in_a scrambled while busy
    for (int i = 0; i < 12; i++) begin
      if (!bus.busy) begin
        bus.in_a = 5;
        bus.in_b = 2;
        bus.in_m = 7;
        sb.push_back(model(5, 2, 7, cyc));
      end else bus.in_a = rnd();
      bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    drain();
    bus.start = 1'b1;
    bus.in_a  = 3;
    bus.in_b  = 10;
    bus.in_m  = 17;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk_i("midop_busy", int'(bus.busy), 1);
    chk_i("midop_wrapped", int'(bus.wrapped), 1);
    resetn = 1'b0;
    #1;
    chk_w("abort_result", bus.result, '0);
    chk_i("abort_wrapped", int'(bus.wrapped), 0);
    chk_i("abort_done", int'(bus.done), 0);
    chk_i("abort_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    op(10, 3, 17);
    drain();
    for (int i = 0; i < 30; i++) begin
      m = rnd() >> $urandom_range(0, 1024);
      if (m == 0) m = 1;
      a = rnd() % m;
      b = ($urandom_range(0, 7) == 0) ? a : rnd() % m;
      op(a, b, m);
    end
    drain();
    chk_i("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
